// File: rtl/rf_pkg.sv
// Register-file shared types: write-port record and address helpers for regfile, decode and writeback.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package rf_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // One regfile write: destination register and the value to store.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } rf_wr_t;

  // x0 is hardwired to zero, so writes to it must never assert the write enable.
  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] a);
    return (a == '0);
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Round-robin picker: first set request at or after the pointer, wrapping, as one-hot plus index.
// Latency: purely combinational.
// Backpressure: none here; the caller masks the grant when it cannot accept.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  // Scan from the pointer position, wrapping once around; the first request seen wins.
  always_comb begin
    int            k;
    logic [PW-1:0] kk;
    logic          found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = 0;
    kk    = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr_i) + i;
      if (k >= N) k = k - N;
      kk = PW'(k);
      if (!found && req_i[kk]) begin
        found     = 1'b1;
        gnt_o[kk] = 1'b1;
        idx_o     = kk;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single regfile write port among NUM_SRC writeback sources, round-robin (optional RF_WB_FWD_EN bypass).
// Latency: handshake in cycle N -> registered write presented in cycle N+1.
// Backpressure: one-hot ready to a single valid source per cycle; i_hold withholds all grants.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int CNT_W   = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_hold,
  input  logic [NUM_SRC-1:0]      i_src_valid,
  input  logic [NUM_SRC*5-1:0]    i_src_addr,
  input  logic [NUM_SRC*32-1:0]   i_src_data,
  output logic [NUM_SRC-1:0]      o_src_ready,
`ifdef RF_WB_FWD_EN
  input  logic [REG_ADDR_W-1:0]   i_rs1_addr,
  input  logic [REG_ADDR_W-1:0]   i_rs2_addr,
  input  logic [XLEN-1:0]         i_rs1_rf_data,
  input  logic [XLEN-1:0]         i_rs2_rf_data,
  output logic [XLEN-1:0]         o_rs1_data,
  output logic [XLEN-1:0]         o_rs2_data,
`endif
  output logic                    o_rd_wren,
  output logic [REG_ADDR_W-1:0]   o_rd_addr,
  output logic [XLEN-1:0]         o_rd_data,
  output logic [CNT_W-1:0]        o_conflict_cnt
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PW-1:0]      ptr_q, ptr_d;
  rf_wr_t             wr_q, wr_d;
  logic               wren_q, wren_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_SRC-1:0] gnt;
  logic [PW-1:0]      gidx;
  logic               gany;
  logic               hs;
  rf_wr_t             sel_wr;

  rr_arbiter #(.N(NUM_SRC), .PW(PW)) u_rr (
    .req_i (i_src_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (gany)
  );

  // A grant is offered only outside hold and reset; it completes immediately since grant implies valid.
  always_comb begin
    hs          = gany & ~i_hold & ~i_rst;
    o_src_ready = hs ? gnt : '0;
    sel_wr.addr = i_src_addr[int'(gidx)*REG_ADDR_W +: REG_ADDR_W];
    sel_wr.data = i_src_data[int'(gidx)*XLEN +: XLEN];
  end

  // Next state: capture the winner, advance the pointer past it, count contended cycles.
  always_comb begin
    ptr_d  = ptr_q;
    wr_d   = wr_q;
    wren_d = 1'b0;
    cnt_d  = cnt_q;
    if (hs) begin
      wr_d   = sel_wr;
      wren_d = ~is_x0(sel_wr.addr);
      ptr_d  = (gidx == PW'(NUM_SRC - 1)) ? '0 : gidx + 1'b1;
    end
    if (!i_hold && ($countones(i_src_valid) >= 2) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset drops any in-flight write at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q  <= '0;
      wr_q   <= '0;
      wren_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      wr_q   <= wr_d;
      wren_q <= wren_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_rd_wren      = wren_q;
  assign o_rd_addr      = wr_q.addr;
  assign o_rd_data      = wr_q.data;
  assign o_conflict_cnt = cnt_q;

`ifdef RF_WB_FWD_EN
  // Bypass the pending write to readers of the same register; x0 always reads the regfile value.
  always_comb begin
    o_rs1_data = i_rs1_rf_data;
    o_rs2_data = i_rs2_rf_data;
    if (wren_q && !is_x0(i_rs1_addr) && (i_rs1_addr == wr_q.addr)) o_rs1_data = wr_q.data;
    if (wren_q && !is_x0(i_rs2_addr) && (i_rs2_addr == wr_q.addr)) o_rs2_data = wr_q.data;
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed writeback scenarios plus a per-cycle reference model.
// Latency: model predicts the registered write one cycle after each grant.
// Backpressure: sources hold valid until granted, then drop it; i_hold exercised directly.
module tb_rf_wb_arbiter;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          hold;
  logic [N-1:0]  src_valid;
  logic [N*5-1:0]  src_addr;
  logic [N*32-1:0] src_data;
  logic [N-1:0]  src_ready;
  logic          rd_wren;
  logic [4:0]    rd_addr;
  logic [31:0]   rd_data;
  logic [15:0]   conflict_cnt;
  logic [4:0]    rs1_addr, rs2_addr;
  logic [31:0]   rs1_rf_data, rs2_rf_data;
  logic [31:0]   rs1_data, rs2_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.NUM_SRC(N), .CNT_W(16)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_hold         (hold),
    .i_src_valid    (src_valid),
    .i_src_addr     (src_addr),
    .i_src_data     (src_data),
    .o_src_ready    (src_ready),
`ifdef RF_WB_FWD_EN
    .i_rs1_addr     (rs1_addr),
    .i_rs2_addr     (rs2_addr),
    .i_rs1_rf_data  (rs1_rf_data),
    .i_rs2_rf_data  (rs2_rf_data),
    .o_rs1_data     (rs1_data),
    .o_rs2_data     (rs2_data),
`endif
    .o_rd_wren      (rd_wren),
    .o_rd_addr      (rd_addr),
    .o_rd_data      (rd_data),
    .o_conflict_cnt (conflict_cnt)
  );

`ifndef RF_WB_FWD_EN
  assign rs1_data = 32'h0;
  assign rs2_data = 32'h0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic [4:0] a, input logic [31:0] d);
    src_addr[5*k +: 5]   = a;
    src_data[32*k +: 32] = d;
  endtask

  // Reference model: pointer, pending write and conflict count as plain integers.
  int          m_ptr;
  bit          m_wren;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_cnt;

  always @(negedge clk) begin
    int g, bestd, d, nv;
    logic [N-1:0] exp_rdy;
    if (rst) begin
      m_ptr = 0; m_wren = 0; m_addr = 0; m_data = 0; m_cnt = 0;
      chk("rst_wren", rd_wren, 0);
      chk("rst_addr", rd_addr, 0);
      chk("rst_data", rd_data, 0);
      chk("rst_cnt", conflict_cnt, 0);
      chk("rst_ready", src_ready, 0);
    end else begin
      chk("m_wren", rd_wren, m_wren);
      chk("m_addr", rd_addr, m_addr);
      chk("m_data", rd_data, m_data);
      chk("m_cnt", conflict_cnt, m_cnt);
`ifdef RF_WB_FWD_EN
      chk("m_rs1", rs1_data, (m_wren && rs1_addr != 0 && rs1_addr == m_addr) ? m_data : rs1_rf_data);
      chk("m_rs2", rs2_data, (m_wren && rs2_addr != 0 && rs2_addr == m_addr) ? m_data : rs2_rf_data);
`endif
      // Winner is the valid source at the smallest forward distance from the pointer.
      g = -1; bestd = N; nv = 0;
      for (int k = 0; k < N; k++) begin
        if (src_valid[k]) begin
          nv++;
          d = (k - m_ptr + N) % N;
          if (d < bestd) begin bestd = d; g = k; end
        end
      end
      exp_rdy = '0;
      if (!hold && g >= 0) exp_rdy[g] = 1'b1;
      chk("m_ready", src_ready, exp_rdy);
      if (!hold && g >= 0) begin
        m_addr = src_addr[5*g +: 5];
        m_data = src_data[32*g +: 32];
        m_wren = (m_addr != 0);
        m_ptr  = (g + 1) % N;
      end else begin
        m_wren = 0;
      end
      if (!hold && nv >= 2 && m_cnt < 65535) m_cnt++;
    end
  end

  initial begin
    rst = 1'b1; hold = 1'b0; src_valid = '0; src_addr = '0; src_data = '0;
    rs1_addr = '0; rs2_addr = '0; rs1_rf_data = '0; rs2_rf_data = '0;
    repeat (2) step();
    chk("reset_wren", rd_wren, 0);
    chk("reset_cnt", conflict_cnt, 0);
    rst = 1'b0;
    step();

    // Single source: src1 -> ready 010, write appears next cycle.
    set_src(1, 5'd5, 32'hDEADBEEF); src_valid = 3'b010;
    #1 chk("single_ready", src_ready, 3'b010);
    step(); src_valid = '0;
    #1 chk("single_wren", rd_wren, 1);
    chk("single_addr", rd_addr, 5);
    chk("single_data", rd_data, 32'hDEADBEEF);

    // Pointer now 2: src2 alone, then pointer returns to 0.
    set_src(2, 5'd9, 32'h22222222); src_valid = 3'b100;
    #1 chk("wrap_ready", src_ready, 3'b100);
    step(); src_valid = '0;

    // Round-robin with all three requesting.
    set_src(0, 5'd1, 32'h100); set_src(1, 5'd2, 32'h200); set_src(2, 5'd3, 32'h300);
    src_valid = 3'b111;
    #1 chk("rr_g0", src_ready, 3'b001);
    step(); src_valid = 3'b110;
    #1 chk("rr_g1", src_ready, 3'b010);
    chk("rr_w0_addr", rd_addr, 1);
    chk("rr_w0_data", rd_data, 32'h100);
    step(); src_valid = 3'b100;
    #1 chk("rr_g2", src_ready, 3'b100);
    chk("rr_w1_data", rd_data, 32'h200);
    step(); src_valid = '0;
    #1 chk("rr_w2_data", rd_data, 32'h300);
    chk("rr_cnt", conflict_cnt, 2);

    // x0 write: handshake completes, no write enable.
    set_src(0, 5'd0, 32'h1234); src_valid = 3'b001;
    #1 chk("x0_ready", src_ready, 3'b001);
    step(); src_valid = '0;
    #1 chk("x0_wren", rd_wren, 0);
    chk("x0_addr", rd_addr, 0);
    chk("x0_data", rd_data, 32'h1234);

    // Hold: granted write drains, then four cycles with no grant and no counting.
    set_src(1, 5'd6, 32'h66); src_valid = 3'b010;
    #1 chk("pre_hold_ready", src_ready, 3'b010);
    step();
    set_src(0, 5'd10, 32'hA0); set_src(2, 5'd4, 32'h44);
    src_valid = 3'b101; hold = 1'b1;
    #1 chk("hold_ready0", src_ready, 0);
    chk("hold_drain_wren", rd_wren, 1);
    chk("hold_drain_addr", rd_addr, 6);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_ready", src_ready, 0);
      chk("hold_wren", rd_wren, 0);
      chk("hold_cnt", conflict_cnt, 2);
    end
    step(); hold = 1'b0;
    #1 chk("unhold_ready", src_ready, 3'b100);
    step(); src_valid = 3'b001;
    #1 chk("unhold_addr", rd_addr, 4);
    chk("unhold_cnt", conflict_cnt, 3);
    chk("after_ready", src_ready, 3'b001);
    step(); src_valid = '0;
    #1 chk("after_addr", rd_addr, 10);

    // Forwarding of the pending write.
    set_src(0, 5'd7, 32'hA5A5A5A5); src_valid = 3'b001;
    step(); src_valid = '0;
    rs1_addr = 5'd7; rs1_rf_data = 32'h0; rs2_addr = 5'd0; rs2_rf_data = 32'h55;
`ifdef RF_WB_FWD_EN
    #1 chk("fwd_rs1", rs1_data, 32'hA5A5A5A5);
    chk("fwd_rs2", rs2_data, 32'h55);
    step();
    chk("fwd_rs1_idle", rs1_data, 32'h0);
`else
    step();
`endif

    // Same rd from two sources: grant order src1 then src2, later value last.
    set_src(1, 5'd12, 32'hB1); set_src(2, 5'd12, 32'hB2); src_valid = 3'b110;
    step(); src_valid = 3'b100;
    #1 chk("same_rd_first", rd_data, 32'hB1);
    step(); src_valid = '0;
    #1 chk("same_rd_last", rd_data, 32'hB2);

    // Asynchronous reset mid-cycle with a write in flight.
    set_src(0, 5'd8, 32'h88); src_valid = 3'b001;
    step();
    chk("pre_arst_wren", rd_wren, 1);
    #2 rst = 1'b1;
    #1 chk("arst_wren", rd_wren, 0);
    chk("arst_addr", rd_addr, 0);
    chk("arst_data", rd_data, 0);
    chk("arst_cnt", conflict_cnt, 0);
    chk("arst_ready", src_ready, 0);
    step();
    chk("arst_ready_hold", src_ready, 0);
    rst = 1'b0; src_valid = '0;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
